row_sync_arbiter: RTL and testbench
===================================

ROW_SYNC_ARBITER -- requirements
Module: row_sync_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4, number of cores sharing one URAM row (2..16).
REQ-002 Parameter ADDR_W, default 12, URAM address width.
REQ-003 Parameter DATA_W, default 32, URAM data width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_core_req  input  NUM_CORES  per-core lock request.
REQ-007 i_core_locked  input  NUM_CORES  per-core "holding lock" status.
REQ-008 o_core_grant  output  NUM_CORES  per-core grant, one-hot or zero.
REQ-009 o_uram_emptied  output  1  broadcast to all cores; URAM holds no undrained data.
REQ-010 i_core_uram_en / i_core_uram_wr_en  input  NUM_CORES each  per-core URAM enable / write enable.
REQ-011 i_core_uram_addr / i_core_uram_wr_data  input  NUM_CORES*ADDR_W / NUM_CORES*DATA_W  per-core packed address / data.
REQ-012 o_URAM_en, o_URAM_wr_en  output  1 each  muxed URAM enable / write enable.
REQ-013 o_URAM_addr / o_URAM_wr_data  output  ADDR_W / DATA_W  muxed URAM address / data.
REQ-014 i_host_drained  input  1  single-cycle pulse: host has emptied the URAM.
REQ-015 o_wr_count  output  16  URAM writes accepted since last drain.
REQ-016 o_illegal_wr  output  1  sticky: a non-owner attempted a URAM access.

Function
REQ-017 FSM states IDLE, GRANT, RELEASE; owner index register owner and round-robin pointer rr_ptr.
REQ-018 IDLE: if any i_core_req set, select first requester at or after rr_ptr (wrapping modulo NUM_CORES), load owner, go GRANT; o_core_grant[owner] rises on the cycle after that edge (one-cycle req-to-grant latency).
REQ-019 IDLE with no requests: stay IDLE, o_core_grant all zero.
REQ-020 GRANT: o_core_grant[owner] held high, all other bits low; locked_seen flag set when i_core_locked[owner] observed high.
REQ-021 GRANT exit: when locked_seen and i_core_locked[owner] low (falling edge of locked), or when i_core_req[owner] and i_core_locked[owner] both low with locked_seen clear; go RELEASE.
REQ-022 RELEASE: one cycle, grant all zero, rr_ptr <= owner+1 modulo NUM_CORES, then IDLE; no back-to-back grant to any core without this gap cycle.
REQ-023 URAM mux: in GRANT, o_URAM_* registered copies of owner's i_core_uram_* (one-cycle latency); otherwise o_URAM_en and o_URAM_wr_en are 0.
REQ-024 Any i_core_uram_en from a non-owner (or any core outside GRANT) sets o_illegal_wr; access discarded; flag cleared only by reset.
REQ-025 o_wr_count increments on each forwarded write (o_URAM_en && o_URAM_wr_en), wraps 0xFFFF -> 0.
REQ-026 o_uram_emptied cleared on the first forwarded write; set when i_host_drained pulses, which also zeroes o_wr_count.
REQ-027 Forwarded write and i_host_drained in same cycle: drain wins (count 0, emptied 1); that write is counted from the next drain epoch as count 1 and clears emptied next cycle.
REQ-028 Owner locked falls and another core requests in same cycle: RELEASE first, new grant per REQ-018 rotation.

Reset
REQ-029 On reset: state IDLE, rr_ptr 0, owner 0, locked_seen 0, o_core_grant 0, o_URAM_en/wr_en 0, o_URAM_addr/wr_data 0, o_wr_count 0, o_uram_emptied 1, o_illegal_wr 0.
REQ-030 Reset mid-GRANT drops grant and URAM enables the following cycle; in-flight registered write is discarded.

Structure
REQ-031 Shared package riscv_pkg holds the FSM state enum (arb_state_t) and URAM width constants.
REQ-032 One sub-module rr_pick: combinational round-robin first-set finder (request vector, pointer -> index, valid).

Verification
REQ-033 Single core 0 req at cycle 5 -> grant[0]=1 at cycle 6; 16 writes addr 0..15 -> o_wr_count=16, emptied=0.
REQ-034 Cores 1 and 3 req together, rr_ptr 0 -> core 1 granted; core 1 locked falls -> 1 gap cycle, then core 3 granted.
REQ-035 Core 2 writes while core 0 owns -> o_illegal_wr=1, o_URAM_en stays 0 for that access, core 0 writes unaffected.
REQ-036 Write and i_host_drained same cycle with count 5 -> count 0, emptied 1; next cycle count 1, emptied 0.
REQ-037 Reset asserted while core 0 granted with wr_en high -> next cycle grant 0, o_URAM_en 0, emptied 1, count 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the row-sync URAM arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE -> GRANT -> RELEASE -> IDLE)
//   URAM_*_W    : default URAM row address / data widths
//   WR_CNT_W    : width of the write counter reported to the host
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int URAM_ADDR_W = 12;
  localparam int URAM_DATA_W = 32;
  localparam int WR_CNT_W    = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder.
//   req   : request vector, one bit per core
//   ptr   : index where the search starts (wraps modulo NUM_CORES)
//   idx   : first set index at or after ptr
//   valid : at least one request bit set
module rr_pick #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  // One spare bit so ptr + offset never overflows before the wrap subtract.
  logic [IDX_W:0] pos;

  always_comb begin
    idx   = ptr;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_CORES)) pos = pos - (IDX_W+1)'(NUM_CORES);
      if (!valid && req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/row_sync_arbiter.sv
// Arbitrates one shared URAM row between NUM_CORES cores.
// A core requests, is granted (one-hot), takes its lock, and releases by
// dropping the lock (or by withdrawing the request before ever locking).
// Every release inserts a grant-free RELEASE cycle and advances the
// round-robin pointer past the old owner.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_core_req/i_core_locked   : per-core request / lock-held status
//   o_core_grant               : per-core grant, one-hot or zero
//   i_core_uram_*              : per-core packed URAM requests
//   o_URAM_*                   : owner's request, registered (1 cycle)
//   i_host_drained             : host emptied the URAM (pulse)
//   o_wr_count/o_uram_emptied  : writes since last drain / empty flag
//   o_illegal_wr               : sticky, non-owner touched the URAM
module row_sync_arbiter import riscv_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = URAM_ADDR_W,
  parameter int DATA_W    = URAM_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          i_core_req,
  input  logic [NUM_CORES-1:0]          i_core_locked,
  output logic [NUM_CORES-1:0]          o_core_grant,
  output logic                          o_uram_emptied,
  input  logic [NUM_CORES-1:0]          i_core_uram_en,
  input  logic [NUM_CORES-1:0]          i_core_uram_wr_en,
  input  logic [NUM_CORES*ADDR_W-1:0]   i_core_uram_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   i_core_uram_wr_data,
  output logic                          o_URAM_en,
  output logic                          o_URAM_wr_en,
  output logic [ADDR_W-1:0]             o_URAM_addr,
  output logic [DATA_W-1:0]             o_URAM_wr_data,
  input  logic                          i_host_drained,
  output logic [WR_CNT_W-1:0]           o_wr_count,
  output logic                          o_illegal_wr
);

  localparam int IDX_W = $clog2(NUM_CORES);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, pick_idx;
  logic             locked_seen, locked_seen_nxt, pick_vld;
  logic             own_req, own_lck, in_grant, illegal_hit, fwd_wr, wr_pend;
  logic [WR_CNT_W-1:0] cnt_inc;

  logic [ADDR_W-1:0] core_addr [NUM_CORES];
  logic [DATA_W-1:0] core_data [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign core_addr[g] = i_core_uram_addr[g*ADDR_W +: ADDR_W];
    assign core_data[g] = i_core_uram_wr_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_pick (
    .req   (i_core_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign own_req  = i_core_req[owner];
  assign own_lck  = i_core_locked[owner];
  assign in_grant = (state == ARB_GRANT);

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    rr_ptr_nxt      = rr_ptr;
    locked_seen_nxt = locked_seen;
    o_core_grant    = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick_idx;
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        o_core_grant[owner] = 1'b1;
        if (own_lck) locked_seen_nxt = 1'b1;
        // Release on lock falling edge, or on a request withdrawn unlocked.
        if ((locked_seen && !own_lck) || (!locked_seen && !own_req && !own_lck))
          state_nxt = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        rr_ptr_nxt      = (owner == IDX_W'(NUM_CORES-1)) ? '0 : owner + 1'b1;
        locked_seen_nxt = 1'b0;
        state_nxt       = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      locked_seen <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      locked_seen <= locked_seen_nxt;
    end
  end

  // Anyone enabling the URAM other than the current owner in GRANT.
  always_comb begin
    illegal_hit = 1'b0;
    for (int i = 0; i < NUM_CORES; i++)
      if (i_core_uram_en[i] && !(in_grant && owner == IDX_W'(i))) illegal_hit = 1'b1;
  end

  assign fwd_wr  = o_URAM_en && o_URAM_wr_en;
  assign cnt_inc = WR_CNT_W'(fwd_wr) + WR_CNT_W'(wr_pend);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_URAM_en      <= 1'b0;
      o_URAM_wr_en   <= 1'b0;
      o_URAM_addr    <= '0;
      o_URAM_wr_data <= '0;
      o_illegal_wr   <= 1'b0;
      o_wr_count     <= '0;
      o_uram_emptied <= 1'b1;
      wr_pend        <= 1'b0;
    end else begin
      o_URAM_en    <= in_grant && i_core_uram_en[owner];
      o_URAM_wr_en <= in_grant && i_core_uram_wr_en[owner];
      if (in_grant) begin
        o_URAM_addr    <= core_addr[owner];
        o_URAM_wr_data <= core_data[owner];
      end
      if (illegal_hit) o_illegal_wr <= 1'b1;
      // Drain wins a collision; the colliding write is carried into the
      // new epoch and counted one cycle later.
      if (i_host_drained) begin
        o_wr_count     <= '0;
        o_uram_emptied <= 1'b1;
        wr_pend        <= fwd_wr;
      end else begin
        if (fwd_wr || wr_pend) begin
          o_wr_count     <= o_wr_count + cnt_inc;
          o_uram_emptied <= 1'b0;
        end
        wr_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_row_sync_arbiter.sv
module tb_row_sync_arbiter;
  localparam int N = 4, AW = 12, DW = 32;

  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] i_core_req, i_core_locked, o_core_grant, i_core_uram_en, i_core_uram_wr_en;
  logic [N*AW-1:0] i_core_uram_addr;
  logic [N*DW-1:0] i_core_uram_wr_data;
  logic o_uram_emptied, o_URAM_en, o_URAM_wr_en, i_host_drained, o_illegal_wr;
  logic [AW-1:0] o_URAM_addr;
  logic [DW-1:0] o_URAM_wr_data;
  logic [15:0] o_wr_count;

  int checks = 0, failures = 0;
  int m_ptr, m_cnt;
  logic m_empty;

  row_sync_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .i_core_req(i_core_req), .i_core_locked(i_core_locked),
    .o_core_grant(o_core_grant), .o_uram_emptied(o_uram_emptied),
    .i_core_uram_en(i_core_uram_en), .i_core_uram_wr_en(i_core_uram_wr_en),
    .i_core_uram_addr(i_core_uram_addr), .i_core_uram_wr_data(i_core_uram_wr_data),
    .o_URAM_en(o_URAM_en), .o_URAM_wr_en(o_URAM_wr_en), .o_URAM_addr(o_URAM_addr),
    .o_URAM_wr_data(o_URAM_wr_data), .i_host_drained(i_host_drained),
    .o_wr_count(o_wr_count), .o_illegal_wr(o_illegal_wr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wr();
    i_core_uram_en = '0; i_core_uram_wr_en = '0;
    i_core_uram_addr = '0; i_core_uram_wr_data = '0;
  endtask

  task automatic drive_wr(input int c, input logic en, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr_wr();
    i_core_uram_en[c] = en; i_core_uram_wr_en[c] = wr;
    i_core_uram_addr[c*AW +: AW] = a; i_core_uram_wr_data[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    i_core_req = '0; i_core_locked = '0; i_host_drained = 1'b0; clr_wr();
    reset = 1'b1; step(); step(); reset = 1'b0;
    m_ptr = 0; m_cnt = 0; m_empty = 1'b1;
  endtask

  // Spec rule: first requester at or after the pointer, wrapping.
  function automatic int exp_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction

  // Grant core c (pointer must favour it) and take its lock.
  task automatic grab(input int c);
    i_core_req = '0; i_core_req[c] = 1'b1; step();
    i_core_locked[c] = 1'b1; step();
  endtask

  task automatic drop(input int c);
    clr_wr(); i_core_locked = '0; i_core_req = '0; step(); step();
    m_ptr = (c + 1) % N;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_core_grant !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=0", o_core_grant); end
    checks++; if ({o_URAM_en, o_URAM_wr_en} !== 2'b00) begin failures++; $display("FAIL reset_en got=%b exp=00", {o_URAM_en, o_URAM_wr_en}); end
    checks++; if ({o_URAM_addr, o_URAM_wr_data} !== '0) begin failures++; $display("FAIL reset_addr_data got=%h exp=0", {o_URAM_addr, o_URAM_wr_data}); end
    checks++; if (o_wr_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_wr_count); end
    checks++; if (o_uram_emptied !== 1'b1) begin failures++; $display("FAIL reset_emptied got=%b exp=1", o_uram_emptied); end
    checks++; if (o_illegal_wr !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", o_illegal_wr); end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    i_core_req = 4'b0001;
    checks++; if (o_core_grant !== 4'b0000) begin failures++; $display("FAIL single_pre_grant got=%b exp=0000", o_core_grant); end
    step();
    checks++; if (o_core_grant !== 4'b0001) begin failures++; $display("FAIL single_grant_latency got=%b exp=0001", o_core_grant); end
    i_core_locked[0] = 1'b1; step();
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      drive_wr(0, 1'b1, 1'b1, AW'(i), d); step();
      checks++;
      if ({o_URAM_en, o_URAM_wr_en, o_URAM_addr, o_URAM_wr_data} !== {2'b11, AW'(i), d}) begin
        failures++; $display("FAIL single_fwd[%0d] got=%b/%b/%h/%h exp=1/1/%h/%h", i, o_URAM_en, o_URAM_wr_en, o_URAM_addr, o_URAM_wr_data, AW'(i), d);
      end
    end
    clr_wr(); step();
    checks++; if (o_URAM_en !== 1'b0) begin failures++; $display("FAIL single_en_idle got=%b exp=0", o_URAM_en); end
    checks++; if (o_wr_count !== 16'd16) begin failures++; $display("FAIL single_count got=%0d exp=16", o_wr_count); end
    checks++; if (o_uram_emptied !== 1'b0) begin failures++; $display("FAIL single_emptied got=%b exp=0", o_uram_emptied); end
    i_core_locked = '0; i_core_req = '0; step();
    checks++; if (o_core_grant !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", o_core_grant); end
    step(); m_ptr = 1;
  endtask

  task automatic test_illegal();
    do_reset(); grab(0);
    drive_wr(2, 1'b1, 1'b1, 12'h0AA, 32'hDEAD0002); step();
    checks++; if (o_URAM_en !== 1'b0) begin failures++; $display("FAIL illegal_discard got=%b exp=0", o_URAM_en); end
    checks++; if (o_illegal_wr !== 1'b1) begin failures++; $display("FAIL illegal_flag got=%b exp=1", o_illegal_wr); end
    drive_wr(0, 1'b1, 1'b1, 12'h055, 32'hC0DE0000);
    i_core_uram_en[2] = 1'b1; i_core_uram_addr[2*AW +: AW] = 12'h0BB; step();
    checks++;
    if ({o_URAM_en, o_URAM_addr, o_URAM_wr_data} !== {1'b1, 12'h055, 32'hC0DE0000}) begin
      failures++; $display("FAIL illegal_owner_fwd got=%b/%h/%h exp=1/055/c0de0000", o_URAM_en, o_URAM_addr, o_URAM_wr_data);
    end
    clr_wr(); step();
    checks++; if (o_wr_count !== 16'd1) begin failures++; $display("FAIL illegal_count got=%0d exp=1", o_wr_count); end
    drop(0);
    checks++; if (o_illegal_wr !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", o_illegal_wr); end
  endtask

  task automatic test_drain_collision();
    do_reset(); grab(0);
    for (int i = 0; i < 6; i++) begin
      drive_wr(0, 1'b1, 1'b1, AW'(i), $urandom); step();
    end
    checks++; if (o_wr_count !== 16'd5) begin failures++; $display("FAIL coll_pre_count got=%0d exp=5", o_wr_count); end
    clr_wr(); i_host_drained = 1'b1; step(); i_host_drained = 1'b0;
    checks++; if ({o_wr_count, o_uram_emptied} !== {16'd0, 1'b1}) begin failures++; $display("FAIL coll_drain got=%0d/%b exp=0/1", o_wr_count, o_uram_emptied); end
    step();
    checks++; if ({o_wr_count, o_uram_emptied} !== {16'd1, 1'b0}) begin failures++; $display("FAIL coll_carry got=%0d/%b exp=1/0", o_wr_count, o_uram_emptied); end
    drop(0);
  endtask

  task automatic test_rotation();
    int gap;
    do_reset();
    i_core_req = 4'b1010; step();
    checks++; if (o_core_grant !== 4'b0010) begin failures++; $display("FAIL rot_first got=%b exp=0010", o_core_grant); end
    i_core_locked[1] = 1'b1; step();
    i_core_locked[1] = 1'b0; step();
    checks++; if (o_core_grant !== 4'b0000) begin failures++; $display("FAIL rot_gap got=%b exp=0000", o_core_grant); end
    gap = 1;
    for (int t = 0; t < 6 && o_core_grant === 4'b0000; t++) begin step(); if (o_core_grant === 4'b0000) gap++; end
    checks++; if (o_core_grant !== 4'b1000) begin failures++; $display("FAIL rot_next got=%b exp=1000", o_core_grant); end
    checks++; if (gap < 1) begin failures++; $display("FAIL rot_gap_len got=%0d exp>=1", gap); end
    i_core_req = '0; step();
    checks++; if (o_core_grant !== 4'b0000) begin failures++; $display("FAIL rot_unlocked_release got=%b exp=0000", o_core_grant); end
    step(); m_ptr = 0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset(); grab(0);
    for (int i = 0; i < 2; i++) begin drive_wr(0, 1'b1, 1'b1, AW'(i), $urandom); step(); end
    drive_wr(0, 1'b1, 1'b1, 12'h3, 32'h12345678); reset = 1'b1; step();
    checks++; if (o_core_grant !== 4'b0000) begin failures++; $display("FAIL rst_mid_grant got=%b exp=0000", o_core_grant); end
    checks++; if ({o_URAM_en, o_URAM_wr_en} !== 2'b00) begin failures++; $display("FAIL rst_mid_en got=%b exp=00", {o_URAM_en, o_URAM_wr_en}); end
    checks++; if ({o_wr_count, o_uram_emptied} !== {16'd0, 1'b1}) begin failures++; $display("FAIL rst_mid_cnt got=%0d/%b exp=0/1", o_wr_count, o_uram_emptied); end
    reset = 1'b0; clr_wr(); i_core_req = '0; i_core_locked = '0; step();
    checks++; if ({o_URAM_en, o_wr_count} !== {1'b0, 16'd0}) begin failures++; $display("FAIL rst_mid_inflight got=%b/%0d exp=0/0", o_URAM_en, o_wr_count); end
    m_ptr = 0; m_cnt = 0; m_empty = 1'b1;
  endtask

  task automatic test_random();
    logic [N-1:0] mask, exp_g;
    logic en, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int c, nw;
    do_reset();
    for (int s = 0; s < 24; s++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      c = exp_pick(mask, m_ptr);
      exp_g = '0; exp_g[c] = 1'b1;
      i_core_req = mask; step();
      checks++; if (o_core_grant !== exp_g) begin failures++; $display("FAIL rnd_grant[%0d] got=%b exp=%b mask=%b", s, o_core_grant, exp_g, mask); end
      i_core_req = exp_g;
      if ($urandom_range(0, 3) != 0) begin
        i_core_locked = exp_g; step();
        nw = $urandom_range(1, 8);
        for (int w = 0; w < nw; w++) begin
          en = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
          a = AW'($urandom); d = $urandom;
          drive_wr(c, en, wr, a, d); step();
          checks++;
          if (en ? ({o_URAM_en, o_URAM_wr_en, o_URAM_addr, o_URAM_wr_data} !== {1'b1, wr, a, d}) : (o_URAM_en !== 1'b0)) begin
            failures++; $display("FAIL rnd_fwd[%0d.%0d] got=%b/%b/%h/%h exp=%b/%b/%h/%h", s, w, o_URAM_en, o_URAM_wr_en, o_URAM_addr, o_URAM_wr_data, en, wr, a, d);
          end
          if (en && wr) begin m_cnt++; m_empty = 1'b0; end
        end
      end
      clr_wr(); i_core_locked = '0; i_core_req = '0; step();
      checks++; if (o_core_grant !== '0) begin failures++; $display("FAIL rnd_release[%0d] got=%b exp=0", s, o_core_grant); end
      checks++; if ({o_wr_count, o_uram_emptied} !== {16'(m_cnt), m_empty}) begin failures++; $display("FAIL rnd_count[%0d] got=%0d/%b exp=%0d/%b", s, o_wr_count, o_uram_emptied, m_cnt, m_empty); end
      step(); m_ptr = (c + 1) % N;
      if ($urandom_range(0, 2) == 0) begin
        i_host_drained = 1'b1; step(); i_host_drained = 1'b0;
        m_cnt = 0; m_empty = 1'b1;
        checks++; if ({o_wr_count, o_uram_emptied} !== {16'd0, 1'b1}) begin failures++; $display("FAIL rnd_drain[%0d] got=%0d/%b exp=0/1", s, o_wr_count, o_uram_emptied); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_drain_collision();
    test_rotation();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
